float_to_int: RTL

FLOAT_TO_INT -- requirements
Module: float_to_int

---
 rtl/float_pkg.sv | 39 +++
 rtl/float_pipe_ctrl.sv | 42 ++++
 rtl/float_to_int.sv | 201 ++++++++++++++++++++
 3 files changed

// File: rtl/float_pkg.sv
// Shared floating-point helpers: operand class, decoded-operand struct,
// exponent bias and signed-integer saturation constants. Fields are sized
// for the widest format the float blocks support; users slice to their width.
package float_pkg;

  localparam int FP_EXP_W   = 16;   // unbiased exponent, two's complement
  localparam int FP_MANT_W  = 64;   // mantissa incl. hidden bit, zero-extended
  localparam int FP_CONST_W = 128;  // container for integer saturation values

  typedef enum logic [1:0] {
    FP_ZERO,   // exponent field zero: zero or denormal
    FP_NORM,
    FP_INF,
    FP_NAN
  } fp_class_e;

  typedef struct packed {
    logic                 sign;
    logic [FP_EXP_W-1:0]  uexp;
    logic [FP_MANT_W-1:0] mant;
    fp_class_e            cls;
  } fp_dec_t;

  // Exponent bias for an e_bit-wide exponent field: {(e_bit-1){1'b1}}
  function automatic int fp_bias(input int e_bit);
    return (1 << (e_bit - 1)) - 1;
  endfunction

  // Largest positive two's-complement value of an i_bit-wide integer
  function automatic logic [FP_CONST_W-1:0] int_pos_max(input int i_bit);
    return (FP_CONST_W'(1) << (i_bit - 1)) - FP_CONST_W'(1);
  endfunction

  // Most negative two's-complement value of an i_bit-wide integer
  function automatic logic [FP_CONST_W-1:0] int_neg_min(input int i_bit);
    return FP_CONST_W'(1) << (i_bit - 1);
  endfunction

endpackage

// File: rtl/float_pipe_ctrl.sv
// Generic valid/ready control for a linear pipeline of STAGES registers.
// A stage may load when it is empty or the stage after it can take its
// contents this cycle; the last stage drains through out_ready.
module float_pipe_ctrl #(
  parameter int STAGES = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              out_ready,
  output logic [STAGES-1:0] valid,
  output logic [STAGES-1:0] load
);

  logic [STAGES-1:0] rdy;
  logic [STAGES-1:0] vin;

  // Per-stage readiness, resolved from the output end backwards
  always_comb begin
    rdy = '0;
    vin = {valid[STAGES-2:0], in_valid};
    rdy[STAGES-1] = !valid[STAGES-1] || out_ready;
    for (int i = STAGES - 2; i >= 0; i--) begin
      rdy[i] = !valid[i] || rdy[i+1];
    end
    load     = rdy & vin;
    in_ready = rdy[0] && !rst;
  end

  // Stage valid bits; reset drops everything in flight
  always_ff @(posedge clk) begin
    if (rst) begin
      valid <= '0;
    end else begin
      for (int i = 0; i < STAGES; i++) begin
        if (rdy[i]) valid[i] <= vin[i];
      end
    end
  end

endmodule

// File: rtl/float_to_int.sv
// Float to signed integer converter, 3-stage valid/ready pipeline:
//   S0 decode/unbias, S1 align shift and range check,
//   S2 round, negate and saturate.
// Build option: define FLOAT_TO_INT_ROUND_EN for round-to-nearest-even;
// without it the result truncates toward zero and no guard/sticky exists.
module float_to_int
  import float_pkg::*;
#(
  parameter int E_bit = 8,
  parameter int F_bit = 23,
  parameter int I_bit = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [E_bit+F_bit:0] float_in,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [I_bit-1:0]     int_out,
  output logic                 ovf
);

  localparam int BIAS = fp_bias(E_bit);
  localparam int MW   = F_bit + 1;      // mantissa with hidden bit
  localparam int FB   = F_bit + 2;      // fraction bits kept after alignment
  localparam int XW   = I_bit + FB;     // aligned fixed-point width
  localparam int SHW  = $clog2(XW) + 1;
  localparam logic [I_bit-1:0] POS_MAX = I_bit'(int_pos_max(I_bit));
  localparam logic [I_bit-1:0] NEG_MIN = I_bit'(int_neg_min(I_bit));
  localparam logic signed [FP_EXP_W-1:0] U_BIG = FP_EXP_W'(I_bit);
  localparam logic signed [FP_EXP_W-1:0] U_MIN = FP_EXP_W'(-1);

  logic [2:0] stg_valid;
  logic [2:0] stg_load;

  float_pipe_ctrl #(.STAGES(3)) u_ctrl (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_ready (out_ready),
    .valid     (stg_valid),
    .load      (stg_load)
  );

  assign out_valid = stg_valid[2];

  // ---------------- S0: decode ----------------
  logic [E_bit-1:0] in_exp;
  logic [F_bit-1:0] in_frac;
  fp_dec_t          dec_in;
  fp_dec_t          s0_dec;

  // Split the operand, remove the bias and classify it
  always_comb begin
    in_exp      = float_in[E_bit+F_bit-1:F_bit];
    in_frac     = float_in[F_bit-1:0];
    dec_in      = '0;
    dec_in.sign = float_in[E_bit+F_bit];
    dec_in.uexp = FP_EXP_W'(in_exp) - FP_EXP_W'(BIAS);
    dec_in.mant = FP_MANT_W'({1'b1, in_frac});
    if (in_exp == '0)   dec_in.cls = FP_ZERO;
    else if (&in_exp)   dec_in.cls = (in_frac == '0) ? FP_INF : FP_NAN;
    else                dec_in.cls = FP_NORM;
  end

  // S0 register
  always_ff @(posedge clk) begin
    if (rst)              s0_dec <= '0;
    else if (stg_load[0]) s0_dec <= dec_in;
  end

  // ---------------- S1: align ----------------
  // The mantissa is placed in a fixed-point word with I_bit integer bits and
  // F_bit+2 fraction bits, so u = -1 still lands fully inside the word and
  // the first fraction bit is the guard. Below that only sticky survives;
  // at or above I_bit the value is out of range regardless of rounding.
  logic signed [FP_EXP_W-1:0] s1_u;
  logic [MW-1:0]              s1_m;
  logic [SHW-1:0]             s1_sh;
  logic [XW-1:0]              s1_x;
  logic                       big_n;
  logic                       tiny_n;
  logic [I_bit-1:0]           mag_n;
`ifdef FLOAT_TO_INT_ROUND_EN
  logic                       guard_n;
  logic                       sticky_n;
`endif

  // Shift the mantissa into integer position and flag out-of-range exponents
  always_comb begin
    s1_u   = $signed(s0_dec.uexp);
    s1_m   = MW'(s0_dec.mant);
    big_n  = s1_u >= U_BIG;
    tiny_n = s1_u < U_MIN;
    s1_sh  = SHW'(s1_u + FP_EXP_W'(2));
    s1_x   = (big_n || tiny_n) ? '0 : (XW'(s1_m) << s1_sh);
    mag_n  = I_bit'(s1_x >> FB);
`ifdef FLOAT_TO_INT_ROUND_EN
    guard_n  = s1_x[FB-1];
    sticky_n = tiny_n || (|s1_x[FB-2:0]);
`endif
  end

  logic             s1_sign;
  fp_class_e        s1_cls;
  logic             s1_big;
  logic [I_bit-1:0] s1_mag;
`ifdef FLOAT_TO_INT_ROUND_EN
  logic             s1_guard;
  logic             s1_sticky;
`endif

  // S1 register
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_sign   <= 1'b0;
      s1_cls    <= FP_ZERO;
      s1_big    <= 1'b0;
      s1_mag    <= '0;
`ifdef FLOAT_TO_INT_ROUND_EN
      s1_guard  <= 1'b0;
      s1_sticky <= 1'b0;
`endif
    end else if (stg_load[1]) begin
      s1_sign   <= s0_dec.sign;
      s1_cls    <= s0_dec.cls;
      s1_big    <= big_n;
      s1_mag    <= mag_n;
`ifdef FLOAT_TO_INT_ROUND_EN
      s1_guard  <= guard_n;
      s1_sticky <= sticky_n;
`endif
    end
  end

  // ---------------- S2: round, negate, saturate ----------------
  // The magnitude keeps one extra bit so a round-up carry is seen by the
  // range check. -2^(I_bit-1) is representable, hence the asymmetric limits.
  logic [I_bit:0]   mag_r;
  logic [I_bit-1:0] int_n;
  logic             ovf_n;

  // Final rounding, special-value handling and two's-complement conversion
  always_comb begin
`ifdef FLOAT_TO_INT_ROUND_EN
    mag_r = {1'b0, s1_mag} + (I_bit+1)'(s1_guard && (s1_sticky || s1_mag[0]));
`else
    mag_r = {1'b0, s1_mag};
`endif
    int_n = '0;
    ovf_n = 1'b0;
    case (s1_cls)
      FP_ZERO: begin
        int_n = '0;
        ovf_n = 1'b0;
      end
      FP_NAN: begin
        int_n = POS_MAX;
        ovf_n = 1'b1;
      end
      FP_INF: begin
        int_n = s1_sign ? NEG_MIN : POS_MAX;
        ovf_n = 1'b1;
      end
      default: begin
        if (s1_big) begin
          int_n = s1_sign ? NEG_MIN : POS_MAX;
          ovf_n = 1'b1;
        end else if (s1_sign) begin
          if (mag_r > {1'b0, NEG_MIN}) begin
            int_n = NEG_MIN;
            ovf_n = 1'b1;
          end else begin
            int_n = -mag_r[I_bit-1:0];
          end
        end else begin
          if (mag_r > {1'b0, POS_MAX}) begin
            int_n = POS_MAX;
            ovf_n = 1'b1;
          end else begin
            int_n = mag_r[I_bit-1:0];
          end
        end
      end
    endcase
  end

  // S2 / output register; held while the consumer stalls
  always_ff @(posedge clk) begin
    if (rst) begin
      int_out <= '0;
      ovf     <= 1'b0;
    end else if (stg_load[2]) begin
      int_out <= int_n;
      ovf     <= ovf_n;
    end
  end

endmodule
